fft_frame_ctrl: RTL



---
 rtl/fft_ctrl_pkg.sv | 29 ++
 rtl/fft_st_outreg.sv | 43 ++++
 rtl/fft_frame_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types, widths and frame-length helpers for fft_frame_ctrl
package fft_ctrl_pkg;

  localparam int DATA_W   = 14;
  localparam int CNT_W    = 16;
  localparam int MAX_LOG2 = 12;
  localparam int MIN_LOG2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_FRAME,
    ST_GAP
  } state_e;

  function automatic logic [3:0] clamp_log2(input logic [3:0] n);
    if (n < 4'(MIN_LOG2)) return 4'(MIN_LOG2);
    if (n > 4'(MAX_LOG2)) return 4'(MAX_LOG2);
    return n;
  endfunction

  // Index of the last sample in a frame, i.e. 2^clamp(n) - 1.
  function automatic logic [MAX_LOG2-1:0] len_m1(input logic [3:0] n);
    logic [MAX_LOG2:0] len;
    len = (MAX_LOG2+1)'(1) << clamp_log2(n);
    return MAX_LOG2'(len - (MAX_LOG2+1)'(1));
  endfunction

endpackage

// File: rtl/fft_st_outreg.sv
// rtl/fft_st_outreg.sv - one-entry Avalon-ST output register with load-accept and drop strobes
module fft_st_outreg
  import fft_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sop,
  input  logic              load_eop,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  output logic              taken,
  output logic              drop
);

  logic stall;

  // A beat accepted this cycle frees the register, so a new load can ride the same edge.
  assign stall = src_valid && !src_ready;
  assign taken = load && !stall;
  assign drop  = load && stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_valid <= 1'b0;
      src_data  <= '0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
    end else if (taken) begin
      src_valid <= 1'b1;
      src_data  <= load_data;
      src_sop   <= load_sop;
      src_eop   <= load_eop;
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - cuts the ADC sample stream into fixed-length FFT frames for the FFT FIFO
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [3:0]        cfg_log2_len,
  input  logic [CNT_W-1:0]  cfg_num_frames,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic              cfg_use_trig,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              trig,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_e              state, state_nxt;
  logic [MAX_LOG2-1:0] len_m1_q, smp_cnt;
  logic [CNT_W-1:0]    num_frames_q, gap_q, gap_cnt;
  logic                use_trig_q, stop_pend, trig_q;
  logic                start, eop_acc, last_frame, load_req, taken, drop;
  logic                done_nxt, gap_clr, gap_inc, smp_sop, smp_eop;

  assign start      = (state == ST_IDLE) && cmd_start;
  assign eop_acc    = (state == ST_FRAME) && src_valid && src_ready && src_eop;
  assign last_frame = stop_pend || cmd_stop ||
                      ((num_frames_q != '0) && (frame_cnt + CNT_W'(1) == num_frames_q));
  assign smp_sop    = (smp_cnt == '0);
  assign smp_eop    = (smp_cnt == len_m1_q);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    done_nxt  = 1'b0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    unique case (state)
      ST_IDLE: if (cmd_start) state_nxt = ST_ARM;
      ST_ARM: begin
        if (cmd_stop) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (!use_trig_q || (trig && !trig_q)) begin
          state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        // The sample arriving with the eop handshake already belongs to what follows the frame.
        if (!eop_acc) begin
          load_req = adc_valid;
        end else if (last_frame) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (gap_q == '0) begin
          load_req = adc_valid;
        end else if (!(adc_valid && gap_q == CNT_W'(1))) begin
          state_nxt = ST_GAP;
          gap_clr   = 1'b1;
          gap_inc   = adc_valid;
        end
      end
      ST_GAP: begin
        if (cmd_stop) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (adc_valid) begin
          if (gap_cnt + CNT_W'(1) == gap_q) state_nxt = ST_FRAME;
          else                               gap_inc   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      len_m1_q     <= '0;
      num_frames_q <= '0;
      gap_q        <= '0;
      use_trig_q   <= 1'b0;
      stop_pend    <= 1'b0;
      trig_q       <= 1'b0;
      smp_cnt      <= '0;
      gap_cnt      <= '0;
      frame_cnt    <= '0;
      overflow     <= 1'b0;
      done         <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= done_nxt;
      if (start) begin
        len_m1_q     <= len_m1(cfg_log2_len);
        num_frames_q <= cfg_num_frames;
        gap_q        <= cfg_gap;
        use_trig_q   <= cfg_use_trig;
        stop_pend    <= 1'b0;
        smp_cnt      <= '0;
        frame_cnt    <= '0;
        overflow     <= 1'b0;
      end else begin
        if (drop)    overflow  <= 1'b1;
        if (taken)   smp_cnt   <= smp_eop ? '0 : smp_cnt + MAX_LOG2'(1);
        if (eop_acc) frame_cnt <= frame_cnt + CNT_W'(1);
        if ((state == ST_FRAME) && cmd_stop) stop_pend <= 1'b1;
      end
      if (gap_clr)      gap_cnt <= CNT_W'(gap_inc);
      else if (gap_inc) gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

  fft_st_outreg u_outreg (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .load      (load_req),
    .load_data (adc_data),
    .load_sop  (smp_sop),
    .load_eop  (smp_eop),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .taken     (taken),
    .drop      (drop)
  );

endmodule
